updown_counter_mod: RTL and testbench
=====================================

# updown_counter_mod

Parametrised up/down counter: the next generation of the fixed 16-bit up/down counter. Adds a programmable modulus, a per-cycle step size, count enable, synchronous parallel load, registered carry/borrow pulses and a sticky wrap flag. With the optional saturation mode compiled in, it can clamp at the range limits instead of wrapping. Sits beside the timer/sequencer logic as a general-purpose event or address counter.

## Interface
- WIDTH, 16: counter width in bits; legal range 2..32.
- MODULUS, 2**WIDTH: count range is 0..MODULUS-1; legal 2 <= MODULUS <= 2**WIDTH.
- clock  in  1  single clock; all state changes on the rising edge.
- clear  in  1  synchronous active-high reset; highest priority.
- enable  in  1  count enable; when low, count holds (load is still honoured).
- mode  in  1  direction: 1 = up, 0 = down.
- load  in  1  synchronous parallel load; overrides enable.
- load_value  in  WIDTH  value for load; values >= MODULUS load as MODULUS-1.
- step  in  WIDTH  increment/decrement per enabled cycle; 0 = hold; values >= MODULUS act as MODULUS-1.
- sat  in  1  1 = saturate at limits, 0 = wrap; ignored unless UDC_SATURATE_EN is defined.
- count  out  WIDTH  current count, registered.
- carry  out  1  registered one-cycle pulse: the last up step passed MODULUS-1.
- borrow  out  1  registered one-cycle pulse: the last down step passed below 0.
- wrapped  out  1  sticky: set by any carry/borrow event; cleared only by clear or load.
- at_limit  out  1  combinational: count == MODULUS-1 when mode=1, count == 0 when mode=0.

## Operation
- Priority per edge: clear > load > enable > hold.
- clear=1: count=0, carry=0, borrow=0, wrapped=0.
- load=1: count=min(load_value, MODULUS-1); carry=borrow=0; wrapped=0.
- enable=1, mode=1, s=min(step, MODULUS-1): sum = count + s computed in WIDTH+1 bits.
  - sum <= MODULUS-1: count=sum, carry=0.
  - sum > MODULUS-1, wrap: count = sum - MODULUS, carry=1, wrapped=1.
  - sum > MODULUS-1, saturate: count = MODULUS-1, carry=1, wrapped=1.
- enable=1, mode=0: if count >= s, count = count - s, borrow=0. Otherwise borrow=1, wrapped=1, and count = count + MODULUS - s (wrap) or 0 (saturate).
- Landing exactly on MODULUS-1 or 0 is not an event; only passing beyond a limit raises carry or borrow.
- enable=0 or s=0: count holds; carry=borrow=0 for that cycle.
- carry and borrow are never high in the same cycle.
- mode and step may change on any cycle; each edge uses the values sampled at that edge.

## Timing
- All outputs except at_limit are registered; count, carry and borrow update on the same edge (latency 1 cycle from inputs).
- at_limit follows count and mode combinationally within the same cycle.
- An asserted clear takes effect on the next edge, including mid-count; there is no asynchronous path.
- load and enable in the same cycle: load wins, no count step is applied.
- MODULUS = 2**WIDTH: wrap arithmetic reduces to natural WIDTH-bit overflow and must still flag carry/borrow.

## Configuration
- UDC_SATURATE_EN defined: the sat input selects saturate (1) or wrap (0) per cycle.
- UDC_SATURATE_EN undefined: no saturation logic; sat is ignored and the counter always wraps. Port list is unchanged.

## Test plan
- WIDTH=4, MODULUS=10: clear for 1 cycle, then mode=1, step=1, enable=1 for 12 cycles -> count 1..9, 0, 1, 2; carry high only on the cycle count becomes 0; wrapped=1 thereafter.
- Same config: load 3, then mode=0, step=4 -> count 9 with borrow=1; a further step -> count 5 with borrow=0.
- With UDC_SATURATE_EN and sat=1: load 8, mode=1, step=3 -> count 9 with carry=1; the next step -> 9 with carry=1 again; mode=0 from 2 with step=5 -> count 0 with borrow=1.
- Priority: clear=1, load=1 and enable=1 together -> count 0; load=1 and enable=1 with load_value=12 -> count 9 (clamped), wrapped=0.
- Default WIDTH=16: load 16'hFFFE, step=3, mode=1 -> count 16'h0001 with carry=1; enable=0 -> count holds and carry=0.
- Assert clear mid-count (count=7) -> count 0 on the next edge, all flags 0; at_limit toggles with mode while count=0.

Source files
------------

// File: rtl/updown_counter_mod_if.sv
// Control/status bundle for updown_counter_mod: the master drives count controls,
// the slave (the counter) returns count and event flags.
interface updown_counter_mod_if #(
   parameter int WIDTH = 16
);
   logic             enable;
   logic             mode;
   logic             load;
   logic [WIDTH-1:0] load_value;
   logic [WIDTH-1:0] step;
   logic             sat;
   logic [WIDTH-1:0] count;
   logic             carry;
   logic             borrow;
   logic             wrapped;
   logic             at_limit;

   modport master (
      output enable, mode, load, load_value, step, sat,
      input  count, carry, borrow, wrapped, at_limit
   );

   modport slave (
      input  enable, mode, load, load_value, step, sat,
      output count, carry, borrow, wrapped, at_limit
   );
endinterface

// File: rtl/updown_counter_mod.sv
// Modulo up/down counter with step, load, carry/borrow pulses and sticky wrap flag.
// Define UDC_SATURATE_EN to let the sat input clamp at the range limits instead of wrapping.
module updown_counter_mod #(
   parameter int              WIDTH   = 16,
   parameter longint unsigned MODULUS = 64'd1 << WIDTH
) (
   input  logic                 clock,
   input  logic                 clear,
   updown_counter_mod_if.slave  bus
);
   localparam logic [WIDTH:0]   MOD_W = (WIDTH+1)'(MODULUS);
   localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MODULUS - 64'd1);
   localparam logic [WIDTH:0]   MAX_X = {1'b0, MAX_V};

   logic [WIDTH-1:0] count_q, count_d;
   logic             carry_q, carry_d;
   logic             borrow_q, borrow_d;
   logic             wrapped_q, wrapped_d;
   logic [WIDTH-1:0] step_eff;
   logic [WIDTH:0]   sum;
   logic             sat_mode;

`ifdef UDC_SATURATE_EN
   assign sat_mode = bus.sat;
`else
   logic unused_sat;
   assign unused_sat = bus.sat;
   assign sat_mode   = 1'b0;
`endif

   // One extra bit keeps the overflow visible even when MODULUS == 2**WIDTH.
   assign step_eff = ({1'b0, bus.step} > MAX_X) ? MAX_V : bus.step;
   assign sum      = {1'b0, count_q} + {1'b0, step_eff};

   always_comb begin
      count_d   = count_q;
      carry_d   = 1'b0;
      borrow_d  = 1'b0;
      wrapped_d = wrapped_q;
      if (bus.load) begin
         count_d   = ({1'b0, bus.load_value} > MAX_X) ? MAX_V : bus.load_value;
         wrapped_d = 1'b0;
      end else if (bus.enable) begin
         if (bus.mode) begin
            if (sum > MAX_X) begin
               carry_d   = 1'b1;
               wrapped_d = 1'b1;
               count_d   = sat_mode ? MAX_V : WIDTH'(sum - MOD_W);
            end else begin
               count_d = sum[WIDTH-1:0];
            end
         end else begin
            if (count_q >= step_eff) begin
               count_d = count_q - step_eff;
            end else begin
               borrow_d  = 1'b1;
               wrapped_d = 1'b1;
               // Final value is below MODULUS, so modular WIDTH+1 arithmetic is exact.
               count_d   = sat_mode ? '0 : WIDTH'({1'b0, count_q} + MOD_W - {1'b0, step_eff});
            end
         end
      end
   end

   always_ff @(posedge clock) begin
      if (clear) begin
         count_q   <= '0;
         carry_q   <= 1'b0;
         borrow_q  <= 1'b0;
         wrapped_q <= 1'b0;
      end else begin
         count_q   <= count_d;
         carry_q   <= carry_d;
         borrow_q  <= borrow_d;
         wrapped_q <= wrapped_d;
      end
   end

   assign bus.count    = count_q;
   assign bus.carry    = carry_q;
   assign bus.borrow   = borrow_q;
   assign bus.wrapped  = wrapped_q;
   assign bus.at_limit = bus.mode ? (count_q == MAX_V) : (count_q == '0);
endmodule

// File: tb/tb_updown_counter_mod.sv
// Directed bench: a WIDTH=4/MODULUS=10 counter driven from a vector table, plus
// hand sequences for a default WIDTH=16 counter and the at_limit/saturation corners.
module tb_updown_counter_mod;
   logic clock = 1'b0;
   logic clear_a, clear_b;
   int   checks = 0;
   int   errors = 0;

   always #5 clock = ~clock;

   updown_counter_mod_if #(.WIDTH(4))  bus_a ();
   updown_counter_mod_if #(.WIDTH(16)) bus_b ();

   updown_counter_mod #(.WIDTH(4), .MODULUS(10)) dut_a (
      .clock (clock),
      .clear (clear_a),
      .bus   (bus_a.slave)
   );

   updown_counter_mod dut_b (
      .clock (clock),
      .clear (clear_b),
      .bus   (bus_b.slave)
   );

   typedef struct {
      logic       clr, ld, en, md;
      logic [3:0] lv, stp;
      logic [3:0] e_cnt;
      logic       e_c, e_b, e_w, e_l;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic clr, ld, en, md, input logic [3:0] lv, stp,
                      input logic [3:0] e_cnt, input logic e_c, e_b, e_w, e_l);
      vec_t v;
      v.clr = clr; v.ld = ld; v.en = en; v.md = md; v.lv = lv; v.stp = stp;
      v.e_cnt = e_cnt; v.e_c = e_c; v.e_b = e_b; v.e_w = e_w; v.e_l = e_l;
      vecs.push_back(v);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic drive_a(input logic clr, ld, en, md, st, input logic [3:0] lv, stp);
      @(negedge clock);
      clear_a = clr; bus_a.load = ld; bus_a.enable = en; bus_a.mode = md;
      bus_a.sat = st; bus_a.load_value = lv; bus_a.step = stp;
      @(posedge clock);
      #1;
   endtask

   task automatic drive_b(input logic clr, ld, en, md, input logic [15:0] lv, stp);
      @(negedge clock);
      clear_b = clr; bus_b.load = ld; bus_b.enable = en; bus_b.mode = md;
      bus_b.sat = 1'b0; bus_b.load_value = lv; bus_b.step = stp;
      @(posedge clock);
      #1;
   endtask

   task automatic chk_a(input string tag, input logic [3:0] cnt, input logic c, b, w, l);
      $display("%s: count=%0d carry=%0b borrow=%0b wrapped=%0b at_limit=%0b",
               tag, bus_a.count, bus_a.carry, bus_a.borrow, bus_a.wrapped, bus_a.at_limit);
      chk({tag, ".count"},    32'(bus_a.count),    32'(cnt));
      chk({tag, ".carry"},    32'(bus_a.carry),    32'(c));
      chk({tag, ".borrow"},   32'(bus_a.borrow),   32'(b));
      chk({tag, ".wrapped"},  32'(bus_a.wrapped),  32'(w));
      chk({tag, ".at_limit"}, 32'(bus_a.at_limit), 32'(l));
   endtask

   initial begin
      clear_a = 1'b1; clear_b = 1'b1;
      bus_a.load = 0; bus_a.enable = 0; bus_a.mode = 1; bus_a.sat = 0;
      bus_a.load_value = '0; bus_a.step = '0;
      bus_b.load = 0; bus_b.enable = 0; bus_b.mode = 1; bus_b.sat = 0;
      bus_b.load_value = '0; bus_b.step = '0;

      // clr ld en md lv stp | cnt c b w l
      add(1, 0, 0, 1, 0, 0,   0, 0, 0, 0, 0);
      for (int i = 1; i <= 12; i++)
         add(0, 0, 1, 1, 0, 1, 4'(i % 10), (i == 10), 0, (i >= 10), (i == 9));
      add(0, 1, 1, 0, 3, 4,   3, 0, 0, 0, 0);   // load beats enable
      add(0, 0, 1, 0, 0, 4,   9, 0, 1, 1, 0);   // 3-4 wraps to 9
      add(0, 0, 1, 0, 0, 4,   5, 0, 0, 1, 0);
      add(0, 0, 1, 1, 0, 12,  4, 1, 0, 1, 0);   // step 12 acts as 9
      add(0, 0, 1, 1, 0, 0,   4, 0, 0, 1, 0);   // step 0 holds
      add(0, 0, 0, 0, 0, 3,   4, 0, 0, 1, 0);   // enable low holds
      add(0, 0, 1, 0, 0, 4,   0, 0, 0, 1, 1);   // landing on 0 is no event
      add(1, 1, 1, 1, 5, 1,   0, 0, 0, 0, 0);   // clear beats everything
      add(0, 1, 1, 1, 12, 1,  9, 0, 0, 0, 1);   // load clamps to 9
      add(0, 0, 1, 1, 0, 1,   0, 1, 0, 1, 0);
      for (int i = 1; i <= 7; i++)
         add(0, 0, 1, 1, 0, 1, 4'(i), 0, 0, 1, 0);
      add(1, 0, 1, 1, 0, 1,   0, 0, 0, 0, 0);   // clear mid-count at 7

      for (int i = 0; i < vecs.size(); i++) begin
         drive_a(vecs[i].clr, vecs[i].ld, vecs[i].en, vecs[i].md, 1'b0, vecs[i].lv, vecs[i].stp);
         chk_a($sformatf("vec%0d", i), vecs[i].e_cnt, vecs[i].e_c, vecs[i].e_b, vecs[i].e_w, vecs[i].e_l);
      end

      // at_limit follows mode with no clock edge while count sits at 0.
      @(negedge clock);
      clear_a = 1'b0; bus_a.enable = 1'b0; bus_a.mode = 1'b0;
      #1 chk_a("atlim_down", 0, 0, 0, 0, 1);
      bus_a.mode = 1'b1;
      #1 chk_a("atlim_up", 0, 0, 0, 0, 0);

      drive_a(0, 1, 0, 1, 0, 8, 0);
      chk_a("sat_load8", 8, 0, 0, 0, 0);
`ifdef UDC_SATURATE_EN
      drive_a(0, 0, 1, 1, 1, 0, 3);
      chk_a("sat_up1", 9, 1, 0, 1, 1);
      drive_a(0, 0, 1, 1, 1, 0, 3);
      chk_a("sat_up2", 9, 1, 0, 1, 1);
      drive_a(0, 1, 0, 0, 1, 2, 5);
      chk_a("sat_load2", 2, 0, 0, 0, 0);
      drive_a(0, 0, 1, 0, 1, 0, 5);
      chk_a("sat_down", 0, 0, 1, 1, 1);
`else
      // sat is ignored without the saturation build: 8+3 wraps to 1.
      drive_a(0, 0, 1, 1, 1, 0, 3);
      chk_a("nosat_up", 1, 1, 0, 1, 0);
`endif

      // Full-width counter: natural overflow must still flag carry/borrow.
      drive_b(1, 0, 0, 1, 16'h0, 16'h0);
      drive_b(0, 1, 0, 1, 16'hFFFE, 16'h3);
      $display("b_load: count=%0h", bus_b.count);
      chk("b_load.count", 32'(bus_b.count), 32'hFFFE);
      chk("b_load.at_limit", 32'(bus_b.at_limit), 32'h0);
      drive_b(0, 0, 1, 1, 16'h0, 16'h3);
      $display("b_up: count=%0h carry=%0b wrapped=%0b", bus_b.count, bus_b.carry, bus_b.wrapped);
      chk("b_up.count", 32'(bus_b.count), 32'h0001);
      chk("b_up.carry", 32'(bus_b.carry), 32'h1);
      chk("b_up.wrapped", 32'(bus_b.wrapped), 32'h1);
      drive_b(0, 0, 0, 1, 16'h0, 16'h3);
      $display("b_hold: count=%0h carry=%0b", bus_b.count, bus_b.carry);
      chk("b_hold.count", 32'(bus_b.count), 32'h0001);
      chk("b_hold.carry", 32'(bus_b.carry), 32'h0);
      drive_b(0, 0, 1, 0, 16'h0, 16'h3);
      $display("b_down: count=%0h borrow=%0b carry=%0b", bus_b.count, bus_b.borrow, bus_b.carry);
      chk("b_down.count", 32'(bus_b.count), 32'hFFFE);
      chk("b_down.borrow", 32'(bus_b.borrow), 32'h1);
      chk("b_down.carry", 32'(bus_b.carry), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
